// File: rtl/control_host_pkg.sv
// ============================================================================
// Module : control_host_pkg
// Brief  : Shared constants, channel indices and step-FSM encoding for
//          control_host_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package control_host_pkg;

    localparam int CH_FWD   = 0;
    localparam int CH_BACK  = 1;
    localparam int CH_LEFT  = 2;
    localparam int CH_RIGHT = 3;

    localparam int N_CH_DEFAULT = 4;

    // Channel i code lives at [8*i +: 8]: ch0='w', ch1='s', ch2='a', ch3='d'.
    localparam logic [8*N_CH_DEFAULT-1:0] DEFAULT_KEY_CODES = {8'h64, 8'h61, 8'h73, 8'h77};

    // ST_HELD is only used when auto-repeat is not built.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } step_state_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_repeat_timer.sv
// ============================================================================
// Module : ctrl_repeat_timer
// Brief  : Per-channel step FSM. Emits a registered step pulse when act rises
//          and, with CONTROL_HOST_REPEAT_EN defined, auto-repeat pulses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ctrl_repeat_timer
    import control_host_pkg::*;
`ifdef CONTROL_HOST_REPEAT_EN
#(
    parameter int CNT_W      = 24,
    parameter int DELAY_CYC  = 5000,
    parameter int REPEAT_CYC = 1000
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic act,
    output logic step
);

    step_state_t r_state;
    step_state_t w_state_nxt;
    logic        r_step;
    logic        w_step_nxt;

    assign step = r_step;

`ifdef CONTROL_HOST_REPEAT_EN
    localparam logic [CNT_W-1:0] C_DELAY_LAST  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] C_REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = 1'b0;
        // Losing act always wins over a step that would fire this cycle.
        if (!act) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_step_nxt  = 1'b1;
                    w_state_nxt = ST_DELAY;
                    w_cnt_nxt   = '0;
                end
                ST_DELAY: begin
                    if (r_cnt == C_DELAY_LAST) begin
                        w_step_nxt  = 1'b1;
                        w_state_nxt = ST_REPEAT;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (r_cnt == C_REPEAT_LAST) begin
                        w_step_nxt = 1'b1;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = 1'b0;
        if (!act) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state == ST_IDLE) begin
            w_step_nxt  = 1'b1;
            w_state_nxt = ST_HELD;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/control_host_seq.sv
// ============================================================================
// Module : control_host_seq
// Brief  : Key-event decoder producing per-channel held levels and step
//          pulses, with stuck-key watchdog. Auto-repeat is built only when
//          CONTROL_HOST_REPEAT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module control_host_seq
    import control_host_pkg::*;
#(
    parameter int                  N_CH        = 4,
    parameter logic [8*N_CH-1:0]   KEY_CODES   = DEFAULT_KEY_CODES,
    parameter int                  CNT_W       = 24,
    parameter int                  DELAY_CYC   = 5000,
    parameter int                  REPEAT_CYC  = 1000,
    parameter int                  TIMEOUT_CYC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            key_valid,
    input  logic [7:0]      key_code,
    input  logic            key_release,
    input  logic [N_CH-1:0] en,
    output logic [N_CH-1:0] held,
    output logic [N_CH-1:0] step,
    output logic            any_held
);

    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [N_CH-1:0]  r_held_r;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [N_CH-1:0]  w_evt_held;
    logic [N_CH-1:0]  w_next_held;
    logic [N_CH-1:0]  w_act;
    logic             w_fire;

    always_comb begin
        w_evt_held = r_held_r;
        for (int i = 0; i < N_CH; i++) begin
            if (key_valid && (KEY_CODES[8*i +: 8] == key_code)) begin
                w_evt_held[i] = ~key_release;
            end
        end
    end

    // Watchdog only fires on an idle cycle; any event (even unmatched) restarts it.
    assign w_fire      = (TIMEOUT_CYC != 0) && !key_valid &&
                         (r_idle_cnt == C_TIMEOUT_LAST) && (|r_held_r);
    assign w_next_held = w_fire ? '0 : w_evt_held;
    assign w_act       = w_next_held & en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held_r   <= '0;
            r_idle_cnt <= '0;
            held       <= '0;
            any_held   <= 1'b0;
        end else begin
            r_held_r <= w_next_held;
            held     <= w_act;
            any_held <= |w_act;
            if (key_valid) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt != '1) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    if (DELAY_CYC >= 1 && REPEAT_CYC >= 1) begin : g_timers
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            ctrl_repeat_timer
`ifdef CONTROL_HOST_REPEAT_EN
            #(
                .CNT_W      (CNT_W),
                .DELAY_CYC  (DELAY_CYC),
                .REPEAT_CYC (REPEAT_CYC)
            )
`endif
            u_timer (
                .clk  (clk),
                .rst  (rst),
                .act  (w_act[i]),
                .step (step[i])
            );
        end
    end else begin : g_bad_cfg
        // Out-of-range timing parameters: steps are suppressed entirely.
        assign step = '0;
    end

endmodule

`default_nettype wire

// File: tb/tb_control_host_seq.sv
`default_nettype none

module tb_control_host_seq;

    localparam int N_CH        = 4;
    localparam int CNT_W       = 24;
    localparam int DELAY_CYC   = 4;
    localparam int REPEAT_CYC  = 3;
    localparam int TIMEOUT_CYC = 20;
`ifdef CONTROL_HOST_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif
    localparam logic [7:0] CODES [N_CH] = '{8'h77, 8'h73, 8'h61, 8'h64};

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            key_valid = 1'b0;
    logic [7:0]      key_code = 8'h00;
    logic            key_release = 1'b0;
    logic [N_CH-1:0] en = 4'hF;
    logic [N_CH-1:0] held;
    logic [N_CH-1:0] step;
    logic            any_held;

    control_host_seq #(
        .N_CH        (N_CH),
        .KEY_CODES   ({8'h64, 8'h61, 8'h73, 8'h77}),
        .CNT_W       (CNT_W),
        .DELAY_CYC   (DELAY_CYC),
        .REPEAT_CYC  (REPEAT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .en          (en),
        .held        (held),
        .step        (step),
        .any_held    (any_held)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: key-down set, idle-cycle count, and per-channel age since activation.
    logic [N_CH-1:0] m_key;
    logic [N_CH-1:0] m_prev_act;
    int              m_age [N_CH];
    int              m_idle;
    logic [N_CH-1:0] e_held;
    logic [N_CH-1:0] e_step;
    logic            e_any;

    task automatic model_reset();
        m_key = '0;
        m_prev_act = '0;
        m_idle = 0;
        e_held = '0;
        e_step = '0;
        e_any = 1'b0;
        for (int i = 0; i < N_CH; i++) m_age[i] = 0;
    endtask

    task automatic model_step();
        logic [N_CH-1:0] nk;
        logic [N_CH-1:0] act;
        bit              fire;
        fire = !key_valid && (m_idle == TIMEOUT_CYC - 1) && (m_key != '0);
        nk = m_key;
        if (key_valid)
            for (int i = 0; i < N_CH; i++)
                if (CODES[i] == key_code) nk[i] = !key_release;
        if (fire) nk = '0;
        if (key_valid) m_idle = 0;
        else if (m_idle < (1 << CNT_W) - 1) m_idle++;
        act = nk & en;
        for (int i = 0; i < N_CH; i++) begin
            if (act[i]) begin
                m_age[i] = m_prev_act[i] ? m_age[i] + 1 : 0;
                e_step[i] = (m_age[i] == 0) ||
                            (REPEAT_ON && m_age[i] >= DELAY_CYC &&
                             ((m_age[i] - DELAY_CYC) % REPEAT_CYC) == 0);
            end else begin
                e_step[i] = 1'b0;
            end
        end
        m_prev_act = act;
        m_key = nk;
        e_held = act;
        e_any = |act;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic kv, input logic [7:0] code, input logic rel);
        key_valid = kv;
        key_code = code;
        key_release = rel;
    endtask

    task automatic check(input string name, input logic [3:0] eh, input logic [3:0] es, input logic ea);
        n_vec++;
        if (held !== eh || step !== es || any_held !== ea) begin
            n_err++;
            $display("FAIL %s @%0t: held=%b step=%b any_held=%b, expected held=%b step=%b any_held=%b",
                     name, $time, held, step, any_held, eh, es, ea);
        end
    endtask

    task automatic check_val(input string name, input int act_v, input int exp_v);
        n_vec++;
        if (act_v != exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act_v, exp_v);
        end
    endtask

    task automatic check_model(input string name);
        check(name, e_held, e_step, e_any);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
        en = 4'hF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       kv;
        logic [7:0] code;
        logic       rel;
        logic [3:0] held;
        logic [3:0] stp;
        logic       rep_only;
    } vec_t;

    function automatic vec_t mk(input logic kv, input logic [7:0] code, input logic rel,
                                input logic [3:0] h, input logic [3:0] s, input logic r);
        vec_t v;
        v.kv = kv; v.code = code; v.rel = rel; v.held = h; v.stp = s; v.rep_only = r;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [12];
        int   cnt;
        tbl[0]  = mk(1'b1, 8'h77, 1'b0, 4'b0001, 4'b0001, 1'b0);
        tbl[1]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0);
        tbl[2]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0);
        tbl[3]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0);
        tbl[4]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0001, 1'b1);
        tbl[5]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0);
        tbl[6]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0);
        tbl[7]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0001, 1'b1);
        tbl[8]  = mk(1'b0, 8'h00, 1'b0, 4'b0001, 4'b0000, 1'b0);
        tbl[9]  = mk(1'b1, 8'h77, 1'b1, 4'b0000, 4'b0000, 1'b0);
        tbl[10] = mk(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0);
        tbl[11] = mk(1'b0, 8'h00, 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Reset state
        do_reset();
        check("reset", 4'b0000, 4'b0000, 1'b0);

        // Single key press, repeat train, release
        for (int r = 0; r < 12; r++) begin
            drive(tbl[r].kv, tbl[r].code, tbl[r].rel);
            tick();
            check($sformatf("table_row%0d", r), tbl[r].held,
                  (tbl[r].rep_only && !REPEAT_ON) ? 4'b0000 : tbl[r].stp, |tbl[r].held);
        end

        // Two keys on consecutive strobes
        do_reset();
        drive(1'b1, 8'h61, 1'b0); tick(); check_model("two_keys_a");
        drive(1'b1, 8'h64, 1'b0); tick();
        check("two_keys_b", 4'b1100, 4'b1000, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 12; k++) begin tick(); check_model("two_keys_train"); end

        // Enable masking and re-enable as fresh press
        do_reset();
        drive(1'b1, 8'h73, 1'b0); tick(); check_model("en_press");
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 2; k++) begin tick(); check_model("en_pre"); end
        en = 4'b1101;
        for (int k = 0; k < 6; k++) begin tick(); check_model("en_masked"); end
        en = 4'hF;
        tick();
        check("en_reenable", 4'b0010, 4'b0010, 1'b1);
        for (int k = 0; k < 5; k++) begin tick(); check_model("en_restart"); end

        // Watchdog with a re-press that restarts it
        do_reset();
        drive(1'b1, 8'h77, 1'b0); tick(); check_model("wd_press");
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin tick(); check_model("wd_idle1"); end
        drive(1'b1, 8'h77, 1'b0); tick();
        check_val("wd_repress_no_step", int'(step[0]), 0);
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 19; k++) begin tick(); check_model("wd_idle2"); end
        check_val("wd_still_held", int'(held[0]), 1);
        tick();
        check_val("wd_released", int'(held[0]), 0);
        check_model("wd_released_all");

        // Unmatched code, re-press of held key, release of unheld key
        do_reset();
        drive(1'b1, 8'h77, 1'b0); tick(); check_model("nochg_press");
        drive(1'b1, 8'h78, 1'b0); tick(); check("nochg_unmatched", 4'b0001, 4'b0000, 1'b1);
        drive(1'b1, 8'h77, 1'b0); tick(); check("nochg_repress", 4'b0001, 4'b0000, 1'b1);
        drive(1'b1, 8'h73, 1'b1); tick(); check("nochg_rel_unheld", 4'b0001, 4'b0000, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // Asynchronous reset in the middle of a repeat train
        do_reset();
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin tick(); check_model("ar_train"); end
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 4'b0000, 4'b0000, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin tick(); check_model("ar_after"); cnt += int'(step[0]); end
        check_val("ar_no_step", cnt, 0);
        drive(1'b1, 8'h77, 1'b0); tick();
        check("ar_new_press", 4'b0001, 4'b0001, 1'b1);
        drive(1'b0, 8'h00, 1'b0);

        // 50-cycle hold, re-pressing to keep the watchdog away
        do_reset();
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (k % 10 == 0) drive(1'b1, 8'h77, 1'b0);
            else drive(1'b0, 8'h00, 1'b0);
            tick();
            check_model("hold50");
            cnt += int'(step[0]);
        end
        check_val("hold50_steps", cnt, REPEAT_ON ? 17 : 1);

        // Randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            int sel;
            bit slow;
            slow = ((k / 60) % 2) == 1;
            sel = $urandom_range(0, 5);
            drive($urandom_range(0, slow ? 29 : 2) == 0,
                  (sel < 4) ? CODES[sel] : ((sel == 4) ? 8'h78 : 8'($urandom)),
                  $urandom_range(0, 2) == 0);
            en = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            tick();
            check_model("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
